// File: rtl/operand_loader_pkg.sv
// Shared operand width, FSM state encoding and next-operand helper for the ALU front end.
// Combinational definitions only; no latency, no backpressure.
package operand_loader_pkg;

    localparam int OL_WIDTH = 4;

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        READY  = 2'b10
    } ol_state_e;

    // Next operand/state on a load press; invalid states fall back to an empty pair.
    typedef struct packed {
        logic       load_a;
        logic       load_b;
        logic       valid;
        ol_state_e  state;
    } ol_step_t;

    function automatic ol_step_t ol_load_step(input ol_state_e cur);
        ol_step_t s;
        s = '{load_a: 1'b0, load_b: 1'b0, valid: 1'b0, state: LOAD_A};
        case (cur)
            LOAD_A: s = '{load_a: 1'b1, load_b: 1'b0, valid: 1'b0, state: LOAD_B};
            LOAD_B: s = '{load_a: 1'b0, load_b: 1'b1, valid: 1'b1, state: READY};
            READY:  s = '{load_a: 1'b1, load_b: 1'b0, valid: 1'b0, state: LOAD_B};
            default: s = '{load_a: 1'b0, load_b: 1'b0, valid: 1'b0, state: LOAD_A};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/operand_loader_button_debouncer.sv
// Synchronizes and debounces one raw push-button; level follows after DEBOUNCE_CYCLES stable samples.
// Latency: level moves DEBOUNCE_CYCLES+2 edges after the raw change; press is a 1-cycle pulse, no backpressure.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);
    import operand_loader_pkg::*;

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_q;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_level_q <= r_level;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == TERM) begin
                // Terminal count reached: accept the new level; counter never wraps.
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign level = r_level;
    assign press = r_level & ~r_level_q;

endmodule

// File: rtl/operand_loader.sv
// Captures operand A then B from switches on debounced load presses; clear press empties the pair.
// Latency: outputs update one edge after the debounced level rises; no backpressure (presses always accepted).
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int WIDTH           = OL_WIDTH,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_load,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             valid,
    output logic [1:0]       state
);

    logic w_load_press;
    logic w_clear_press;
    logic w_load_level_unused;
    logic w_clear_level_unused;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_load),
        .level   (w_load_level_unused),
        .press   (w_load_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_clear),
        .level   (w_clear_level_unused),
        .press   (w_clear_press)
    );

    ol_state_e        r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_valid;

    ol_state_e        w_state_nxt;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic             w_valid_nxt;
    ol_step_t         w_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LOAD_A;
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_valid_nxt = r_valid;
        w_step      = ol_load_step(r_state);

        if (w_clear_press) begin
            // Clear outranks a coincident load press.
            w_state_nxt = LOAD_A;
            w_a_nxt     = '0;
            w_b_nxt     = '0;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                LOAD_A, LOAD_B, READY: begin
                    if (w_load_press) begin
                        w_state_nxt = w_step.state;
                        w_valid_nxt = w_step.valid;
                        if (w_step.load_a) w_a_nxt = sw;
                        if (w_step.load_b) w_b_nxt = sw;
                    end
                end
                default: begin
                    w_state_nxt = LOAD_A;
                    w_a_nxt     = '0;
                    w_b_nxt     = '0;
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    assign A     = r_a;
    assign B     = r_b;
    assign valid = r_valid;
    assign state = r_state;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with a short debounce window and a scoreboard of expected outputs.
module tb_operand_loader;

    localparam int W  = 4;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sw = '0;
    logic         btn_load = 1'b0;
    logic         btn_clear = 1'b0;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         valid;
    logic [1:0]   state;

    operand_loader #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .btn_load  (btn_load),
        .btn_clear (btn_clear),
        .A         (A),
        .B         (B),
        .valid     (valid),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         v;
        logic [1:0]   s;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;

    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic         m_v = 1'b0;
    logic [1:0]   m_s = 2'b00;

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_a = '0; m_b = '0; m_v = 1'b0; m_s = 2'b00;
    endtask

    task automatic model_press(input logic ld, input logic cl, input logic [W-1:0] swv);
        if (cl) begin
            model_reset();
        end else if (ld) begin
            case (m_s)
                2'b00: begin m_a = swv; m_v = 1'b0; m_s = 2'b01; end
                2'b01: begin m_b = swv; m_v = 1'b1; m_s = 2'b10; end
                2'b10: begin m_a = swv; m_v = 1'b0; m_s = 2'b01; end
                default: model_reset();
            endcase
        end
    endtask

    task automatic push_exp();
        sb.push_back('{a: m_a, b: m_b, v: m_v, s: m_s});
    endtask

    task automatic cmp(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, observed A=%b B=%b", tag, A, B);
        end else begin
            e = sb.pop_front();
            cmp({tag, ".A"}, A, e.a);
            cmp({tag, ".B"}, B, e.b);
            cmp({tag, ".valid"}, {3'b000, valid}, {3'b000, e.v});
            cmp({tag, ".state"}, {2'b00, state}, {2'b00, e.s});
        end
    endtask

    // Hold buttons 10 cycles: check edge 6 (no change) and edge 7 (update), then release.
    task automatic do_press(input string tag, input logic ld, input logic cl, input logic [W-1:0] swv);
        sw = swv;
        btn_load = ld;
        btn_clear = cl;
        edges(6);
        push_exp();
        check_pop({tag, "_e6"});
        model_press(ld, cl, swv);
        edges(1);
        push_exp();
        check_pop({tag, "_e7"});
        edges(3);
        btn_load = 1'b0;
        btn_clear = 1'b0;
        edges(10);
        push_exp();
        check_pop({tag, "_rel"});
    endtask

    initial begin
        logic [W-1:0] and_exp;

        reset = 1'b1;
        edges(2);
        reset = 1'b0;
        model_reset();
        push_exp();
        check_pop("reset");
        for (int i = 0; i < 20; i++) begin
            edges(1);
            push_exp();
            check_pop("idle");
        end

        do_press("load_a", 1'b1, 1'b0, 4'b1010);
        do_press("load_b", 1'b1, 1'b0, 4'b0110);

        and_exp = 4'b0010;
        edges(1);
        cmp("and_stage", A & B, and_exp);

        for (int i = 0; i < 30; i++) begin
            btn_load = ~btn_load;
            sw = W'(i);
            edges(1);
        end
        btn_load = 1'b0;
        sw = 4'b1001;
        edges(10);
        push_exp();
        check_pop("bounce");

        btn_load = 1'b1;
        edges(3);
        btn_load = 1'b0;
        edges(10);
        push_exp();
        check_pop("pulse3");

        do_press("reload", 1'b1, 1'b0, 4'b1111);

        sw = 4'b0000;
        edges(5);
        push_exp();
        check_pop("sw_only");

        do_press("clear_pri", 1'b1, 1'b1, 4'b0101);

        sw = 4'b1100;
        btn_load = 1'b1;
        edges(3);
        reset = 1'b1;
        edges(1);
        reset = 1'b0;
        model_reset();
        push_exp();
        check_pop("mid_reset");
        edges(3);
        push_exp();
        check_pop("mid_reset_e7");
        edges(3);
        push_exp();
        check_pop("mid_reset_e10");
        model_press(1'b1, 1'b0, 4'b1100);
        edges(1);
        push_exp();
        check_pop("mid_reset_e11");
        btn_load = 1'b0;
        edges(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
